// File: rtl/sad_pkg.sv
// Shared types and default widths for the sad_accum SAD scoring stage.
package sad_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int ROW_W_DEF = 4;
  localparam int COL_W_DEF = 3;
  localparam int SAD_W_DEF = 16;
  localparam int CNT_W_DEF = 7;

  localparam logic [SAD_W_DEF-1:0] SAD_MAX = {SAD_W_DEF{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sad_accum_if.sv
// Pixel-pair stream into sad_accum: valid/ready handshake plus candidate framing.
interface sad_accum_if #(
  parameter int PIX_W = 8,
  parameter int ROW_W = 4,
  parameter int COL_W = 3
);

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] img_pix;
  logic [PIX_W-1:0] tpl_pix;
  logic             pix_last;
  logic             search_last;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  modport master (
    output pix_valid, img_pix, tpl_pix, pix_last, search_last, row, col,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, img_pix, tpl_pix, pix_last, search_last, row, col,
    output pix_ready
  );

endinterface

// File: rtl/sad_accum_abs_diff.sv
// Combinational unsigned absolute difference of two pixel values.
module abs_diff #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] y
);

  always_comb begin
    y = (a >= b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/sad_accum.sv
// sad_accum: streams pixel pairs per candidate, accumulates SAD, keeps the best candidate.
// Build option: define SAD_SAT_EN to saturate the accumulator instead of wrapping.
module sad_accum
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int SAD_W = SAD_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sad_accum_if.slave       pix,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [ROW_W-1:0] best_row,
  output logic [COL_W-1:0] best_col,
  output logic [CNT_W-1:0] cand_cnt
);

  function automatic logic [SAD_W-1:0] acc_add(input logic [SAD_W-1:0] a,
                                               input logic [SAD_W-1:0] b);
    logic [SAD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`ifdef SAD_SAT_EN
    return sum[SAD_W] ? {SAD_W{1'b1}} : sum[SAD_W-1:0];
`else
    return sum[SAD_W-1:0];
`endif
  endfunction

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             open_q, open_d;
  logic             last_q, last_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [ROW_W-1:0] best_row_q, best_row_d;
  logic [COL_W-1:0] best_col_q, best_col_d;
  logic [CNT_W-1:0] cand_cnt_q, cand_cnt_d;

  logic             vld_p0_q, vld_p0_d;
  logic [PIX_W-1:0] diff_p0_q, diff_p0_d;
  logic [SAD_W-1:0] acc_p1_q, acc_p1_d;

  logic             xfer;
  logic [PIX_W-1:0] abs_y;

  abs_diff #(.PIX_W(PIX_W)) u_abs_diff (
    .a (pix.img_pix),
    .b (pix.tpl_pix),
    .y (abs_y)
  );

  always_comb begin
    xfer = pix.pix_valid & ready_q;
  end

  always_comb begin
    state_d    = state_q;
    open_d     = open_q;
    last_d     = last_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    best_sad_d = best_sad_q;
    best_row_d = best_row_q;
    best_col_d = best_col_q;
    cand_cnt_d = cand_cnt_q;
    // Stage p0: registered absolute difference of the accepted pair
    vld_p0_d   = 1'b0;
    diff_p0_d  = diff_p0_q;
    // Stage p1: accumulator absorbs the p0 difference one edge later
    acc_p1_d   = vld_p0_q ? acc_add(acc_p1_q, SAD_W'(diff_p0_q)) : acc_p1_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          best_sad_d = {SAD_W{1'b1}};
          best_row_d = '0;
          best_col_d = '0;
          cand_cnt_d = '0;
          acc_p1_d   = '0;
          open_d     = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          vld_p0_d  = 1'b1;
          diff_p0_d = abs_y;
          open_d    = 1'b1;
          if (!open_q) begin
            cur_row_d = pix.row;
            cur_col_d = pix.col;
          end
          if (pix.pix_last) begin
            last_d  = pix.search_last;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = CMP;
      end
      CMP: begin
        // Strict compare: on a tie the earlier candidate keeps the slot
        if (acc_p1_q < best_sad_q) begin
          best_sad_d = acc_p1_q;
          best_row_d = cur_row_q;
          best_col_d = cur_col_q;
        end
        cand_cnt_d = cand_cnt_q + CNT_W'(1);
        acc_p1_d   = '0;
        open_d     = 1'b0;
        state_d    = last_q ? DONE : ACCUM;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == ACCUM);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      open_q     <= 1'b0;
      last_q     <= 1'b0;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      best_sad_q <= {SAD_W{1'b1}};
      best_row_q <= '0;
      best_col_q <= '0;
      cand_cnt_q <= '0;
      vld_p0_q   <= 1'b0;
      acc_p1_q   <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      open_q     <= open_d;
      last_q     <= last_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      best_sad_q <= best_sad_d;
      best_row_q <= best_row_d;
      best_col_q <= best_col_d;
      cand_cnt_q <= cand_cnt_d;
      vld_p0_q   <= vld_p0_d;
      acc_p1_q   <= acc_p1_d;
    end
  end

  // The difference value is qualified by vld_p0_q, so it needs no reset
  always_ff @(posedge clk) begin
    diff_p0_q <= diff_p0_d;
  end

  assign pix.pix_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign best_sad      = best_sad_q;
  assign best_row      = best_row_q;
  assign best_col      = best_col_q;
  assign cand_cnt      = cand_cnt_q;

endmodule

// File: tb/tb_sad_accum.sv
// Self-checking bench for sad_accum: directed and randomized searches against an array model.
module tb_sad_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sstart = 1'b0;

  always #5 clk = ~clk;

  sad_accum_if #(.PIX_W(8), .ROW_W(4), .COL_W(3)) bus ();
  sad_accum_if #(.PIX_W(8), .ROW_W(4), .COL_W(3)) sbus ();

  logic        busy, done;
  logic [15:0] best_sad;
  logic [3:0]  best_row;
  logic [2:0]  best_col;
  logic [6:0]  cand_cnt;

  logic        s_busy, s_done;
  logic [7:0]  s_best_sad;
  logic [3:0]  s_best_row;
  logic [2:0]  s_best_col;
  logic [6:0]  s_cand_cnt;

  sad_accum #(.PIX_W(8), .ROW_W(4), .COL_W(3), .SAD_W(16), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .pix(bus),
    .busy(busy), .done(done), .best_sad(best_sad),
    .best_row(best_row), .best_col(best_col), .cand_cnt(cand_cnt)
  );

  sad_accum #(.PIX_W(8), .ROW_W(4), .COL_W(3), .SAD_W(8), .CNT_W(7)) dut_sat (
    .clk(clk), .rst(rst), .start(sstart), .pix(sbus),
    .busy(s_busy), .done(s_done), .best_sad(s_best_sad),
    .best_row(s_best_row), .best_col(s_best_col), .cand_cnt(s_cand_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus tables: up to 6 candidates of up to 6 pixel pairs
  int img_a [6][6];
  int tpl_a [6][6];
  int len_a [6];
  int row_a [6];
  int col_a [6];

  task automatic idle_bus();
    bus.pix_valid = 0; bus.img_pix = 0; bus.tpl_pix = 0; bus.pix_last = 0;
    bus.search_last = 0; bus.row = 0; bus.col = 0;
    sbus.pix_valid = 0; sbus.img_pix = 0; sbus.tpl_pix = 0; sbus.pix_last = 0;
    sbus.search_last = 0; sbus.row = 0; sbus.col = 0;
  endtask

  task automatic run_search(input int ncand, input bit b2b, input bit gaps,
                            input bit start_pulse, input string tag);
    int exp_sad [6];
    int best, brow, bcol, s, w, exp_w;
    bit gap;
    logic [15:0] held_sad;
    for (int c = 0; c < ncand; c++) begin
      s = 0;
      for (int p = 0; p < len_a[c]; p++)
        s += (img_a[c][p] > tpl_a[c][p]) ? img_a[c][p] - tpl_a[c][p] : tpl_a[c][p] - img_a[c][p];
      exp_sad[c] = s % 65536;
    end
    best = 65535; brow = 0; bcol = 0;
    for (int c = 0; c < ncand; c++)
      if (exp_sad[c] < best) begin best = exp_sad[c]; brow = row_a[c]; bcol = col_a[c]; end

    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int c = 0; c < ncand; c++) begin
      for (int p = 0; p < len_a[c]; p++) begin
        gap = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
          bus.pix_valid = 0; gap = 1;
          @(posedge clk); #1;
        end
        bus.pix_valid   = 1;
        bus.img_pix     = img_a[c][p][7:0];
        bus.tpl_pix     = tpl_a[c][p][7:0];
        bus.pix_last    = (p == len_a[c] - 1);
        bus.search_last = (p == len_a[c] - 1) ? (c == ncand - 1) : 1'($urandom_range(0, 1));
        bus.row         = (p == 0) ? 4'(row_a[c]) : 4'($urandom_range(0, 15));
        bus.col         = (p == 0) ? 3'(col_a[c]) : 3'($urandom_range(0, 7));
        if (start_pulse && c == 1 && p == 0) start = 1;
        w = 0;
        while (bus.pix_ready !== 1'b1 && w < 10) begin
          @(posedge clk); #1; w++;
        end
        exp_w = (c > 0 && p == 0) ? (gap ? 1 : 2) : 0;
        n_checks++;
        if (w !== exp_w) begin
          n_fail++;
          $display("FAIL %s ready_wait c%0d p%0d: waited %0d cycles, expected %0d", tag, c, p, w, exp_w);
          if (w >= 10) begin idle_bus(); start = 0; return; end
        end
        @(posedge clk); #1;
        start = 0;
        if (start_pulse && c == 1 && p == 0) begin
          n_checks++;
          if (cand_cnt !== 7'd1 || best_sad !== 16'(exp_sad[0])) begin
            n_fail++;
            $display("FAIL %s start_ignored: cnt %0d sad %0d, expected cnt 1 sad %0d", tag, cand_cnt, best_sad, exp_sad[0]);
          end
        end
      end
      if (!b2b || c == ncand - 1) bus.pix_valid = 0;
    end

    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || bus.pix_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s drain: done %b ready %b busy %b, expected 0 0 1", tag, done, bus.pix_ready, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s done_pulse: done %b, expected 1", tag, done);
    end
    n_checks++;
    if (best_sad !== 16'(best) || best_row !== 4'(brow) || best_col !== 3'(bcol)) begin
      n_fail++;
      $display("FAIL %s best: sad %0d row %0d col %0d, expected %0d %0d %0d", tag, best_sad, best_row, best_col, best, brow, bcol);
    end
    n_checks++;
    if (cand_cnt !== 7'(ncand)) begin
      n_fail++; $display("FAIL %s cand_cnt: %0d, expected %0d", tag, cand_cnt, ncand);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s done_end: done %b busy %b, expected 0 0", tag, done, busy);
    end
    held_sad = best_sad;
    bus.pix_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    bus.pix_valid = 0;
    n_checks++;
    if (best_sad !== held_sad || bus.pix_ready !== 1'b0 || cand_cnt !== 7'(ncand)) begin
      n_fail++;
      $display("FAIL %s idle_hold: sad %0d ready %b cnt %0d, expected %0d 0 %0d", tag, best_sad, bus.pix_ready, cand_cnt, held_sad, ncand);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    n_checks++;
    if (busy !== 0 || done !== 0 || bus.pix_ready !== 0 || best_sad !== 16'hFFFF ||
        best_row !== 0 || best_col !== 0 || cand_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_values: busy %b done %b ready %b sad %h row %0d col %0d cnt %0d",
               busy, done, bus.pix_ready, best_sad, best_row, best_col, cand_cnt);
    end
  endtask

  task automatic test_reset_mid_accum();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    bus.pix_valid = 1; bus.img_pix = 8'd50; bus.tpl_pix = 8'd10; bus.pix_last = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    bus.pix_valid = 0;
    @(posedge clk); #1 rst = 0;
    n_checks++;
    if (busy !== 0 || best_sad !== 16'hFFFF || cand_cnt !== 0 || bus.pix_ready !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_accum: busy %b sad %h cnt %0d ready %b, expected 0 ffff 0 0",
               busy, best_sad, cand_cnt, bus.pix_ready);
    end
  endtask

  task automatic test_three_cand();
    int img [3][4] = '{'{10, 20, 30, 40}, '{5, 5, 5, 5}, '{200, 0, 100, 50}};
    int tpl [3][4] = '{'{0, 10, 20, 30}, '{8, 2, 8, 2}, '{190, 10, 95, 45}};
    for (int c = 0; c < 3; c++) begin
      len_a[c] = 4; row_a[c] = 0; col_a[c] = c;
      for (int p = 0; p < 4; p++) begin img_a[c][p] = img[c][p]; tpl_a[c][p] = tpl[c][p]; end
    end
    run_search(3, 0, 0, 0, "three_cand");
    n_checks++;
    if (best_sad !== 16'd12 || best_col !== 3'd1 || cand_cnt !== 7'd3) begin
      n_fail++;
      $display("FAIL three_cand_direct: sad %0d col %0d cnt %0d, expected 12 1 3", best_sad, best_col, cand_cnt);
    end
  endtask

  task automatic test_tie();
    len_a[0] = 2; row_a[0] = 1; col_a[0] = 0;
    img_a[0][0] = 3; tpl_a[0][0] = 0; img_a[0][1] = 7; tpl_a[0][1] = 9;
    len_a[1] = 1; row_a[1] = 1; col_a[1] = 1;
    img_a[1][0] = 100; tpl_a[1][0] = 105;
    run_search(2, 0, 0, 0, "tie");
    n_checks++;
    if (best_sad !== 16'd5 || best_row !== 4'd1 || best_col !== 3'd0) begin
      n_fail++;
      $display("FAIL tie_direct: sad %0d row %0d col %0d, expected 5 1 0", best_sad, best_row, best_col);
    end
  endtask

  task automatic fill_random(input int ncand);
    for (int c = 0; c < ncand; c++) begin
      len_a[c] = $urandom_range(1, 6);
      row_a[c] = $urandom_range(0, 15);
      col_a[c] = $urandom_range(0, 7);
      for (int p = 0; p < 6; p++) begin
        img_a[c][p] = $urandom_range(0, 255);
        tpl_a[c][p] = $urandom_range(0, 255);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random(4);
    run_search(4, 1, 0, 0, "back_to_back");
  endtask

  task automatic test_start_ignored();
    fill_random(3);
    run_search(3, 0, 0, 1, "start_ignored");
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 15; i++) begin
      n = $urandom_range(1, 6);
      fill_random(n);
      run_search(n, 0, 1, 0, "random");
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_sad;
    int w;
`ifdef SAD_SAT_EN
    exp_sad = 8'd255;
`else
    exp_sad = 8'd252;
`endif
    @(posedge clk); #1 sstart = 1;
    @(posedge clk); #1 sstart = 0;
    sbus.pix_valid = 1; sbus.img_pix = 8'd255; sbus.tpl_pix = 8'd0;
    sbus.row = 4'd2; sbus.col = 3'd3;
    for (int p = 0; p < 4; p++) begin
      sbus.pix_last = (p == 3); sbus.search_last = (p == 3);
      @(posedge clk); #1;
    end
    sbus.pix_valid = 0; sbus.pix_last = 0; sbus.search_last = 0;
    w = 0;
    while (s_done !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    n_checks++;
    if (s_done !== 1'b1 || s_best_sad !== exp_sad || s_cand_cnt !== 7'd1) begin
      n_fail++;
      $display("FAIL saturation: done %b sad %0d cnt %0d, expected 1 %0d 1", s_done, s_best_sad, s_cand_cnt, exp_sad);
    end
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_reset_mid_accum();
    test_three_cand();
    test_tie();
    test_back_to_back();
    test_start_ignored();
    test_random();
    test_saturation();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_accum.md
# sad_accum

Search-grid scoring stage fed by the coordinate generator. For each candidate position (row, col), it streams the candidate's image/template pixel pairs and accumulates their sum of absolute differences (SAD). It keeps the lowest-SAD candidate of the current search and reports it with a one-cycle `done` pulse after the final candidate. The matched coordinates feed the result/report logic downstream.

## Interface
- `PIX_W`, 8: pixel width.
- `ROW_W`, 4: row coordinate width.
- `COL_W`, 3: column coordinate width.
- `SAD_W`, 16: accumulator and score width.
- `CNT_W`, 7: candidate counter width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a new search; honoured only in IDLE.
- `pix_valid`  in  1  pixel pair present.
- `pix_ready`  out  1  block accepts a pair; transfer = `pix_valid & pix_ready`.
- `img_pix`  in  PIX_W  image pixel.
- `tpl_pix`  in  PIX_W  template pixel.
- `pix_last`  in  1  last pair of the current candidate.
- `search_last`  in  1  current candidate is the final one; sampled with the `pix_last` transfer.
- `row`  in  ROW_W  candidate row; sampled on the candidate's first transfer.
- `col`  in  COL_W  candidate column; sampled on the candidate's first transfer.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the search completes.
- `best_sad`  out  SAD_W  lowest SAD so far.
- `best_row`  out  ROW_W  row of the best candidate.
- `best_col`  out  COL_W  column of the best candidate.
- `cand_cnt`  out  CNT_W  candidates scored in this search.

## Operation
- States: IDLE, ACCUM, DRAIN, CMP, DONE.
- `pix_ready` is 1 only in ACCUM.
- **IDLE**
  - On `start`: `best_sad` ← all-ones, `best_row`/`best_col` ← 0, `cand_cnt` ← 0, accumulator ← 0, go to ACCUM.
  - `pix_valid` is ignored.
- **ACCUM**
  - On each transfer, register `|img_pix − tpl_pix|` (unsigned, PIX_W bits) into the difference stage. That stage adds into the accumulator on the next edge.
  - The first transfer of a candidate latches `row`/`col` into the candidate registers.
  - A transfer with `pix_last` also latches `search_last` and moves to DRAIN.
- **DRAIN**: final difference is added; go to CMP.
- **CMP**
  - If accumulator < `best_sad` (strict), update `best_sad`, `best_row` and `best_col`. On a tie, the earlier candidate is kept.
  - `cand_cnt` += 1, wrapping modulo 2^CNT_W.
  - Clear the accumulator and the first-pixel flag.
  - Go to DONE if the latched `search_last` is set, else go to ACCUM.
- **DONE**: `done` = 1 for one cycle; go to IDLE.
- `start` outside IDLE is ignored.
- A single-pixel candidate (`pix_last` on the first transfer) is legal.
- Width rule: the difference is zero-extended to SAD_W before the add.
- `rst` at any time forces IDLE and reset values; any in-flight candidate is discarded.
- Reset values: `busy` 0, `done` 0, `pix_ready` 0, `best_sad` all-ones, `best_row` 0, `best_col` 0, `cand_cnt` 0, accumulator 0.

## Timing
- Pipeline: one registered difference stage, then the accumulator.
- For a last transfer at edge t:
  - DRAIN during t..t+1.
  - CMP during t+1..t+2; best outputs updated at edge t+2.
  - `pix_ready` low for exactly 2 cycles between candidates.
- Last candidate: `done` is high during the cycle after edge t+2, then `busy` falls.
- Best outputs are stable from `done` until the next `start`.
- All outputs are registered.

## Configuration
- `SAD_SAT_EN` defined: the accumulator saturates at 2^SAD_W−1 and never wraps.
- `SAD_SAT_EN` undefined: the accumulator wraps modulo 2^SAD_W.

## Structure
- Package `sad_pkg`:
  - state enum (IDLE, ACCUM, DRAIN, CMP, DONE);
  - default width constants;
  - `SAD_MAX` constant.
- Sub-module `abs_diff`: combinational unsigned absolute difference of two PIX_W values. Instantiated once in front of the difference register.

## Test plan
- Reset mid-ACCUM after 2 transfers → next cycle `busy`=0, `best_sad`=0xFFFF, `cand_cnt`=0, `pix_ready`=0.
- 3 candidates of 4 pixels at (0,0),(0,1),(0,2) with SADs 40, 12, 30; last candidate flagged `search_last` → `done` pulse once, `best_sad`=12, `best_col`=1, `cand_cnt`=3.
- Tie: two candidates both scoring SAD 5 at (1,0) then (1,1) → `best_col`=0.
- Back-to-back `pix_valid` held high → `pix_ready` drops for exactly 2 cycles after each `pix_last`; no pair lost or duplicated.
- Saturation with SAD_W=8: 4 pairs of 255/0 → with `SAD_SAT_EN`, `best_sad`=255; without it, `best_sad`=252.
- `start` pulsed during ACCUM → ignored; `cand_cnt` and best values unchanged until the next search.
